// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port memory between an instruction-fetch port and a data port.
// Latency: 2 cycles from grant to ready when m_ack comes back in the first m_req cycle.
// Backpressure: requesters hold req until their ready pulse; busy is high whenever a transaction is open.
// Optional feature: define ARB_TIMEOUT_EN to abort a transaction after TIMEOUT SERVE cycles without m_ack.
module mem_arbiter #(
  parameter int AW          = 32,
  parameter int DW          = 32,
  parameter int MAX_DSTREAK = 4,
  parameter int TIMEOUT     = 15
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_req,
  input  logic [AW-1:0] i_addr,
  output logic [DW-1:0] i_rdata,
  output logic          i_ready,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic [DW-1:0] d_rdata,
  output logic          d_ready,
  output logic          m_req,
  output logic          m_we,
  output logic [AW-1:0] m_addr,
  output logic [DW-1:0] m_wdata,
  input  logic [DW-1:0] m_rdata,
  input  logic          m_ack,
  output logic          busy,
  output logic          err
);

  typedef enum logic [1:0] {IDLE, SERVE_D, SERVE_I, RESP} state_t;

  // The streak counter is 3 bits wide, so the cap must fit in it.
  localparam logic [2:0] MAX_S = 3'(MAX_DSTREAK);

  if (MAX_DSTREAK < 1 || MAX_DSTREAK > 7) begin : g_bad_streak
    $error("mem_arbiter: MAX_DSTREAK must be in 1..7");
  end
  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("mem_arbiter: TIMEOUT must be at least 1");
  end

  state_t        state_q;
  logic [2:0]    streak_q;
  logic [2:0]    streak_d;
  logic [AW-1:0] addr_q;
  logic          we_q;
  logic [DW-1:0] wdata_q;
  logic          m_req_q;
  logic          busy_q;
  logic          i_ready_q;
  logic          d_ready_q;
  logic [DW-1:0] i_rdata_q;
  logic [DW-1:0] d_rdata_q;
  logic          grant_d;
  logic          grant_i;

`ifdef ARB_TIMEOUT_EN
  localparam int        TW       = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
  logic [TW-1:0] tmo_q;
  logic          err_q;
`endif

  // Arbitration decision in IDLE: data wins unless the fetch port has been starved MAX_DSTREAK times.
  always_comb begin
    grant_d  = d_req && !(i_req && (streak_q == MAX_S));
    grant_i  = i_req && !grant_d;
    streak_d = streak_q;
    if (grant_d) begin
      if (!i_req) begin
        streak_d = 3'd0;
      end else if (streak_q != MAX_S) begin
        streak_d = streak_q + 3'd1;
      end
    end else if (grant_i) begin
      streak_d = 3'd0;
    end
  end

  // Transaction FSM; every output is a register updated here.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      streak_q  <= 3'd0;
      addr_q    <= '0;
      we_q      <= 1'b0;
      wdata_q   <= '0;
      m_req_q   <= 1'b0;
      busy_q    <= 1'b0;
      i_ready_q <= 1'b0;
      d_ready_q <= 1'b0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
`ifdef ARB_TIMEOUT_EN
      tmo_q     <= '0;
      err_q     <= 1'b0;
`endif
    end else begin
      // Ready and err are single-cycle pulses.
      i_ready_q <= 1'b0;
      d_ready_q <= 1'b0;
`ifdef ARB_TIMEOUT_EN
      err_q     <= 1'b0;
`endif
      case (state_q)
        IDLE: begin
          if (grant_d || grant_i) begin
            state_q  <= grant_d ? SERVE_D : SERVE_I;
            streak_q <= streak_d;
            addr_q   <= grant_d ? d_addr : i_addr;
            we_q     <= grant_d && d_we;
            wdata_q  <= grant_d ? d_wdata : '0;
            m_req_q  <= 1'b1;
            busy_q   <= 1'b1;
`ifdef ARB_TIMEOUT_EN
            tmo_q    <= '0;
`endif
          end
        end
        SERVE_D, SERVE_I: begin
          if (m_ack) begin
            // Stores also capture m_rdata, so d_rdata reflects the bus at m_ack.
            if (state_q == SERVE_D) begin
              d_rdata_q <= m_rdata;
              d_ready_q <= 1'b1;
            end else begin
              i_rdata_q <= m_rdata;
              i_ready_q <= 1'b1;
            end
            m_req_q <= 1'b0;
            state_q <= RESP;
          end
`ifdef ARB_TIMEOUT_EN
          else if (tmo_q == TMO_LAST) begin
            // Abort: complete the port with zero data and flag the error.
            if (state_q == SERVE_D) begin
              d_rdata_q <= '0;
              d_ready_q <= 1'b1;
            end else begin
              i_rdata_q <= '0;
              i_ready_q <= 1'b1;
            end
            err_q   <= 1'b1;
            m_req_q <= 1'b0;
            state_q <= RESP;
          end else begin
            tmo_q <= tmo_q + 1'b1;
          end
`endif
        end
        RESP: begin
          // Requests are not sampled here so the requester can drop req after ready.
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          m_req_q <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign m_req   = m_req_q;
  assign m_we    = we_q;
  assign m_addr  = addr_q;
  assign m_wdata = wdata_q;
  assign busy    = busy_q;
  assign i_ready = i_ready_q;
  assign d_ready = d_ready_q;
  assign i_rdata = i_rdata_q;
  assign d_rdata = d_rdata_q;
`ifdef ARB_TIMEOUT_EN
  assign err     = err_q;
`else
  assign err     = 1'b0;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: reset, load latency, D/I fairness, store stability,
// mid-transaction reset and the optional timeout abort.
module tb_mem_arbiter;
  logic        clk = 1'b0;
  logic        reset;
  logic        i_req;
  logic [31:0] i_addr;
  logic [31:0] i_rdata;
  logic        i_ready;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [31:0] d_rdata;
  logic        d_ready;
  logic        m_req;
  logic        m_we;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic [31:0] m_rdata;
  logic        m_ack;
  logic        busy;
  logic        err;

  int n_cmp  = 0;
  int n_fail = 0;

  mem_arbiter #(.AW(32), .DW(32), .MAX_DSTREAK(4), .TIMEOUT(15)) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ready(i_ready),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ready(d_ready),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_rdata(m_rdata), .m_ack(m_ack), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1; i_req = 1'b0; i_addr = '0; d_req = 1'b0; d_we = 1'b0;
    d_addr = '0; d_wdata = '0; m_rdata = '0; m_ack = 1'b0;
    tick; tick;
    check("rst_m_req",   m_req,   0);
    check("rst_m_we",    m_we,    0);
    check("rst_m_addr",  m_addr,  0);
    check("rst_m_wdata", m_wdata, 0);
    check("rst_i_ready", i_ready, 0);
    check("rst_d_ready", d_ready, 0);
    check("rst_i_rdata", i_rdata, 0);
    check("rst_d_rdata", d_rdata, 0);
    check("rst_busy",    busy,    0);
    check("rst_err",     err,     0);
    reset = 1'b0;
    tick;

    // Load at 0x100 acked in the first m_req cycle.
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h100;
    tick;
    check("ld_m_req",  m_req,  1);
    check("ld_m_addr", m_addr, 32'h100);
    check("ld_m_we",   m_we,   0);
    check("ld_busy1",  busy,   1);
    check("ld_ready_early", d_ready, 0);
    m_ack = 1'b1; m_rdata = 32'hDEADBEEF;
    tick;
    check("ld_d_ready", d_ready, 1);
    check("ld_i_ready", i_ready, 0);
    check("ld_d_rdata", d_rdata, 32'hDEADBEEF);
    check("ld_m_req_off", m_req, 0);
    check("ld_busy2", busy, 1);
    m_ack = 1'b0; d_req = 1'b0;
    tick;
    check("ld_d_ready_pulse", d_ready, 0);
    check("ld_busy_off", busy, 0);
    check("ld_d_rdata_hold", d_rdata, 32'hDEADBEEF);

    // Both ports requesting continuously: D,D,D,D,I,D,D,D,D,I.
    d_req = 1'b1; d_addr = 32'h300; i_req = 1'b1; i_addr = 32'h400;
    for (int k = 0; k < 10; k++) begin
      logic exp_i;
      exp_i = (k == 4) || (k == 9);
      tick;
      check($sformatf("arb%0d_m_req", k), m_req, 1);
      check($sformatf("arb%0d_m_addr", k), m_addr, exp_i ? 32'h400 : 32'h300);
      m_ack = 1'b1; m_rdata = 32'h1000 + k;
      tick;
      check($sformatf("arb%0d_i_ready", k), i_ready, exp_i);
      check($sformatf("arb%0d_d_ready", k), d_ready, !exp_i);
      check($sformatf("arb%0d_rdata", k), exp_i ? i_rdata : d_rdata, 32'h1000 + k);
      m_ack = 1'b0;
      tick;
    end
    d_req = 1'b0; i_req = 1'b0;

    // Store with m_ack arriving in the fourth m_req cycle.
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h20; d_wdata = 32'h12345678;
    for (int c = 0; c < 4; c++) begin
      tick;
      check($sformatf("st%0d_m_req", c),   m_req,   1);
      check($sformatf("st%0d_m_addr", c),  m_addr,  32'h20);
      check($sformatf("st%0d_m_we", c),    m_we,    1);
      check($sformatf("st%0d_m_wdata", c), m_wdata, 32'h12345678);
      check($sformatf("st%0d_d_ready", c), d_ready, 0);
    end
    m_ack = 1'b1; m_rdata = 32'hCAFEF00D;
    tick;
    check("st_d_ready", d_ready, 1);
    check("st_i_ready", i_ready, 0);
    check("st_d_rdata", d_rdata, 32'hCAFEF00D);
    m_ack = 1'b0; d_req = 1'b0; d_we = 1'b0;
    tick;
    check("st_d_ready_pulse", d_ready, 0);
    check("st_busy_off", busy, 0);

    // Reset in SERVE_I, then a stale m_ack after release.
    i_req = 1'b1; i_addr = 32'h40;
    tick;
    check("rs_m_req_pre", m_req, 1);
    check("rs_m_addr_pre", m_addr, 32'h40);
    reset = 1'b1;
    #1;
    check("rs_m_req_async", m_req, 0);
    check("rs_busy_async", busy, 0);
    check("rs_m_addr_async", m_addr, 0);
    #2;
    reset = 1'b0; i_req = 1'b0; m_ack = 1'b1; m_rdata = 32'h55555555;
    tick;
    check("rs_i_ready", i_ready, 0);
    check("rs_m_req", m_req, 0);
    check("rs_busy", busy, 0);
    check("rs_i_rdata", i_rdata, 0);
    m_ack = 1'b0;
    tick;
    check("rs_i_ready2", i_ready, 0);

    // Plain fetch so i_rdata holds a nonzero value.
    i_req = 1'b1; i_addr = 32'h80;
    tick;
    check("f_m_addr", m_addr, 32'h80);
    m_ack = 1'b1; m_rdata = 32'h0BADC0DE;
    tick;
    check("f_i_ready", i_ready, 1);
    check("f_i_rdata", i_rdata, 32'h0BADC0DE);
    m_ack = 1'b0; i_req = 1'b0;
    tick;

    // Fetch that never gets m_ack.
    i_req = 1'b1; i_addr = 32'h44;
    tick;
    check("to_m_req0", m_req, 1);
    for (int k = 1; k < 15; k++) begin
      tick;
      check($sformatf("to%0d_i_ready", k), i_ready, 0);
      check($sformatf("to%0d_err", k), err, 0);
    end
    tick;
`ifdef ARB_TIMEOUT_EN
    check("to_i_ready", i_ready, 1);
    check("to_err", err, 1);
    check("to_i_rdata", i_rdata, 0);
    check("to_m_req", m_req, 0);
    i_req = 1'b0;
    tick;
    check("to_err_pulse", err, 0);
    check("to_i_ready_pulse", i_ready, 0);
`else
    check("to_i_ready", i_ready, 0);
    check("to_err", err, 0);
    check("to_m_req", m_req, 1);
    check("to_busy", busy, 1);
    check("to_i_rdata", i_rdata, 32'h0BADC0DE);
    tick; tick; tick;
    check("to_m_req_late", m_req, 1);
    check("to_err_late", err, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter AW, default 32: address width in bits.
REQ-002 Parameter DW, default 32: data width in bits.
REQ-003 Parameter MAX_DSTREAK, default 4: consecutive data grants allowed while an instruction request waits.
REQ-004 Parameter TIMEOUT, default 15: cycles to wait for m_ack before abort (used only under the configuration macro).
REQ-005 clk  input  1  single clock; all state updates on the rising edge.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 i_req  input  1  instruction-fetch request; held with i_addr until i_ready.
REQ-008 i_addr  input  AW  instruction-fetch address.
REQ-009 i_rdata  output  DW  fetched instruction, valid while i_ready=1.
REQ-010 i_ready  output  1  one-cycle completion pulse for the fetch port.
REQ-011 d_req  input  1  data request; held with d_we, d_addr and d_wdata until d_ready.
REQ-012 d_we  input  1  1 = store, 0 = load.
REQ-013 d_addr  input  AW  data address.
REQ-014 d_wdata  input  DW  store data.
REQ-015 d_rdata  output  DW  load data, valid while d_ready=1.
REQ-016 d_ready  output  1  one-cycle completion pulse for the data port.
REQ-017 m_req  output  1  request to the shared single-port memory.
REQ-018 m_we  output  1  write enable to memory.
REQ-019 m_addr  output  AW  memory address.
REQ-020 m_wdata  output  DW  memory write data.
REQ-021 m_rdata  input  DW  memory read data, valid with m_ack.
REQ-022 m_ack  input  1  memory completion; one cycle per transaction.
REQ-023 busy  output  1  1 whenever state is not IDLE; drives pipeline stall.
REQ-024 err  output  1  one-cycle timeout-abort pulse.

Function
REQ-025 The FSM SHALL have four states: IDLE, SERVE_D, SERVE_I and RESP.
REQ-026 In IDLE, the arbiter SHALL go to SERVE_D if d_req=1, unless i_req=1 and streak=MAX_DSTREAK; otherwise it SHALL go to SERVE_I if i_req=1; otherwise it SHALL stay in IDLE.
REQ-027 On a grant, the arbiter SHALL register address, we and wdata (we=0 for a fetch); m_addr, m_we and m_wdata SHALL come from these registers and stay stable until m_ack.
REQ-028 m_req SHALL equal 1 exactly while in SERVE_D or SERVE_I, so the first m_req is driven in the cycle after the grant.
REQ-029 m_ack=1 in SERVE_x SHALL capture m_rdata into x_rdata and move to RESP; m_ack in any other state SHALL be ignored.
REQ-030 In RESP, the arbiter SHALL assert exactly one of i_ready/d_ready for the served port, then return to IDLE unconditionally; RESP never samples requests, so a requester drops or changes its req after seeing ready.
REQ-031 Minimum latency SHALL be 2 cycles from grant to ready when m_ack arrives in the first m_req cycle.
REQ-032 i_rdata and d_rdata SHALL hold their last captured value between transactions; a store leaves d_rdata = m_rdata as sampled at m_ack.
REQ-033 streak counter (3 bits, saturating at MAX_DSTREAK):
- a data grant while i_req=1 SHALL increment it;
- a data grant while i_req=0, or any instruction grant, SHALL clear it.
REQ-034 i_ready and d_ready SHALL never both be 1, and m_req SHALL never be asserted for two ports at once.

Reset
REQ-035 Reset SHALL asynchronously force state=IDLE, streak=0, m_req=0, m_we=0, m_addr=0, m_wdata=0, i_ready=0, d_ready=0, i_rdata=0, d_rdata=0, busy=0, err=0 and the timeout counter to 0.
REQ-036 Reset mid-transaction SHALL abandon the transaction with no ready pulse; an m_ack arriving after reset release SHALL be ignored.

Configuration
REQ-037 With ARB_TIMEOUT_EN defined, a counter SHALL clear on each grant and increment each SERVE cycle without m_ack; when it reaches TIMEOUT, the arbiter SHALL go to RESP with x_rdata=0, pulse ready, and pulse err=1 in that RESP cycle.
REQ-038 Without ARB_TIMEOUT_EN, err SHALL be tied 0 and SERVE states SHALL wait indefinitely for m_ack.

Verification
REQ-039 d_req load at 0x100, m_ack in the first m_req cycle, m_rdata=0xDEADBEEF -> d_ready 2 cycles after grant with d_rdata=0xDEADBEEF, and busy high for 2 cycles.
REQ-040 d_req and i_req both asserted continuously -> grant order D,D,D,D,I,D,D,D,D,I (MAX_DSTREAK=4).
REQ-041 Store d_we=1 at addr 0x20 with wdata 0x12345678, m_ack delayed 3 cycles -> m_addr, m_we and m_wdata stable for all 4 m_req cycles, then a d_ready pulse with no i_ready.
REQ-042 Reset asserted while in SERVE_I, then m_ack after reset release -> m_req=0 immediately, no i_ready, state IDLE.
REQ-043 ARB_TIMEOUT_EN defined, i_req with no m_ack -> after 15 SERVE cycles, i_ready=1, err=1 and i_rdata=0 in the same cycle; without the macro, the arbiter stays in SERVE_I with err=0.
